round: RTL and testbench
========================

Name: round

Overview:
- Single full AES-128 encryption round (FIPS-197): SubBytes, ShiftRows, MixColumns, AddRoundKey, in that order.
- Purely combinational datapath followed by one output register stage.
- Instantiated per middle round (rounds 1..9) inside the AES cipher datapath.
- The round key comes from the key-expansion block; this block does not expand keys.

Parameters:
- None.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- data_in  input  unpacked array [0:15] of 8-bit  state entering the round; byte index i = 4*c + r (column c, row r, column-major per FIPS-197).
- round_key  input  unpacked array [0:3] of 32-bit  round key words; word c applies to column c; bits [31:24] = row 0, [23:16] = row 1, [15:8] = row 2, [7:0] = row 3.
- data_out  output  unpacked array [0:15] of 8-bit  registered round result, same byte ordering as data_in.

Behaviour:
- Reset:
  - rst high clears all 16 data_out bytes to 8'h00 immediately, without waiting for a clock edge.
  - data_out holds 00 while rst is asserted.
- Latency:
  - data_out on each rising clk edge (rst low) = round(data_in, round_key) sampled at that edge.
  - Exactly 1 cycle latency; no enable and no handshake; the register updates every cycle.
- SubBytes:
  - s[i] = SBOX(data_in[i]) for all 16 bytes.
  - SBOX is the standard AES forward S-box (e.g. 00→63, 01→7c, 53→ed).
  - Implement as a 256-entry constant table (function or case); 16 parallel lookups.
- ShiftRows:
  - Row r rotates left by r positions.
  - sr[4c+r] = s[4*((c+r) mod 4) + r].
- MixColumns, per column c with a0..a3 = sr[4c+0..3]:
  - b0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - b1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - b2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - b3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - Multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00); 3x = xtime(x) ^ x.
- AddRoundKey:
  - out[4c+r] = b_r ^ round_key[c][31-8r -: 8].
- Width rules:
  - All byte arithmetic is 8-bit XOR only; no carries.
- Boundary conditions:
  - X/unknown inputs propagate; no sanitizing.
  - rst deasserted mid-cycle: first capture happens at the next rising edge.
  - rst asserted mid-operation discards the pending result.
  - The final AES round (no MixColumns) is out of scope for this block.

Test Plan:
- Assert rst, with clk running and arbitrary inputs → data_out all 00 before any clock edge; stays 00 while rst is high.
- Release rst; data_in all 00, round_key all 32'h00000000 → after next rising edge, all 16 data_out bytes = 63.
- data_in all 00, round_key all 32'hffffffff → all 16 data_out bytes = 9c.
- FIPS-197 Appendix B round 1:
  - data_in = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08
  - round_key = a0fafe17, 88542cb1, 23a33939, 2a6c7605
  - → data_out = a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49 one edge later.
- Latency check: switch inputs from the FIPS vector to all-zero 0.1 ns after an edge → data_out keeps the FIPS result until the next edge, then becomes all 63.
- Assert rst asynchronously between edges while data_out = a4 9c … → data_out goes to 00 immediately, without a clock edge.

Source files
------------

// File: rtl/round.sv
// ============================================================================
// Module   : round
// Brief    : One registered AES-128 middle round
//            (SubBytes, ShiftRows, MixColumns, AddRoundKey).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module round (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in   [0:15],
  input  logic [31:0] round_key [0:3],
  output logic [7:0]  data_out  [0:15]
);

  localparam logic [7:0] c_sbox [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  logic [7:0] w_sub   [0:15];
  logic [7:0] w_shift [0:15];
  logic [7:0] w_mix   [0:15];
  logic [7:0] w_next  [0:15];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign w_sub[i] = c_sbox[data_in[i]];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    // Row r of column c is taken from column (c+r) mod 4, i.e. a left rotate by r.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_shift[4*c+r] = w_sub[4*((c+r)%4)+r];
    end

    assign w_mix[4*c+0] = xtime(w_shift[4*c+0]) ^ mul3(w_shift[4*c+1]) ^ w_shift[4*c+2] ^ w_shift[4*c+3];
    assign w_mix[4*c+1] = w_shift[4*c+0] ^ xtime(w_shift[4*c+1]) ^ mul3(w_shift[4*c+2]) ^ w_shift[4*c+3];
    assign w_mix[4*c+2] = w_shift[4*c+0] ^ w_shift[4*c+1] ^ xtime(w_shift[4*c+2]) ^ mul3(w_shift[4*c+3]);
    assign w_mix[4*c+3] = mul3(w_shift[4*c+0]) ^ w_shift[4*c+1] ^ w_shift[4*c+2] ^ xtime(w_shift[4*c+3]);

    for (genvar r = 0; r < 4; r++) begin : g_key
      assign w_next[4*c+r] = w_mix[4*c+r] ^ round_key[c][31-8*r -: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '{default: 8'h00};
    end else begin
      data_out <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_round.sv
// ============================================================================
// Module   : tb_round
// Brief    : Self-checking bench for the registered AES round.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_round;

  typedef logic [7:0]  state_t [0:15];
  typedef logic [31:0] key_t   [0:3];

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t data_in;
  key_t   round_key;
  state_t data_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [7:0] sbox_tab [0:255];
  state_t exp_q;
  state_t zero_s;
  state_t all63_s;
  state_t all9c_s;

  state_t fips_in  = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                       8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
  key_t   fips_key = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
  state_t fips_out = '{8'ha4, 8'h9c, 8'h7f, 8'hf2, 8'h68, 8'h9f, 8'h35, 8'h2b,
                       8'h6b, 8'h5b, 8'hea, 8'h43, 8'h02, 8'h6a, 8'h50, 8'h49};

  round dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .round_key (round_key),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: generic GF(2^8) product, inverse plus affine map for the S-box.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic state_t model_round(input state_t din, input key_t key);
    state_t res;
    logic [7:0] coef [0:3];
    logic [7:0] col  [0:3];
    logic [7:0] acc;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        col[r] = sbox_tab[din[4*((c+r)%4)+r]];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - r + 4) % 4], col[k]);
        res[4*c+r] = acc ^ 8'(key[c] >> (24 - 8*r));
      end
    end
    return res;
  endfunction

  function automatic string hexs(input state_t s);
    string t = "";
    for (int i = 0; i < 16; i++) t = {t, $sformatf("%02h", s[i])};
    return t;
  endfunction

  task automatic check_state(input string name, input state_t act, input state_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s at %0t", name, hexs(act), hexs(exp), $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input state_t d, input key_t k);
    data_in   = d;
    round_key = k;
  endtask

  // Expected register contents, following the clock and the asynchronous reset.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q <= zero_s;
    else     exp_q <= model_round(data_in, round_key);
  end

  always @(negedge clk) begin
    if (started) check_state("cycle", data_out, rst ? zero_s : exp_q);
  end

  initial begin
    key_t k0, kf;
    zero_s  = '{default: 8'h00};
    all63_s = '{default: 8'h63};
    all9c_s = '{default: 8'h9c};
    k0 = '{default: 32'h00000000};
    kf = '{default: 32'hffffffff};
    for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_calc(8'(x));

    check_byte("model_sbox_00", sbox_tab[8'h00], 8'h63);
    check_byte("model_sbox_01", sbox_tab[8'h01], 8'h7c);
    check_byte("model_sbox_53", sbox_tab[8'h53], 8'hed);
    check_state("model_fips", model_round(fips_in, fips_key), fips_out);

    drive(fips_in, fips_key);
    #0.5 rst = 1'b1;
    #0.5 check_state("reset_async", data_out, zero_s);
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_state("reset_hold", data_out, zero_s);

    @(negedge clk);
    #1 rst = 1'b0;
    drive(zero_s, k0);
    #1 check_state("reset_release_no_edge", data_out, zero_s);
    @(posedge clk);
    #1 check_state("zero_key0", data_out, all63_s);

    drive(zero_s, kf);
    @(posedge clk);
    #1 check_state("zero_keyff", data_out, all9c_s);

    drive(fips_in, fips_key);
    @(posedge clk);
    #0.1 drive(zero_s, k0);
    #0.9 check_state("fips_round1", data_out, fips_out);
    #3 check_state("latency_hold", data_out, fips_out);
    @(posedge clk);
    #1 check_state("latency_next", data_out, all63_s);

    drive(fips_in, fips_key);
    @(posedge clk);
    #1 check_state("fips_again", data_out, fips_out);
    #2 rst = 1'b1;
    #0.1 check_state("reset_midcycle", data_out, zero_s);
    @(posedge clk);
    #1 check_state("reset_discard", data_out, zero_s);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check_state("post_reset_fips", data_out, fips_out);

    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 16; i++) data_in[i] = 8'($urandom);
      for (int c = 0; c < 4; c++) round_key[c] = $urandom;
    end
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
